// File: rtl/pool_window_if.sv
// Stream bundle between the raster pixel source, pool_window_gen and max_pooling.
// The master drives the pixel stream. The slave (pool_window_gen) returns the 2x2 windows.
interface pool_window_if #(
  parameter int DATA_W = 32
);
  // A pixel transfers on every clock where enable & in_valid are both high. There is
  // no ready: the source paces the stream. out_valid and frame_done are single-cycle
  // pulses, and out_tl..out_br hold their values between pulses.
  logic              enable;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_tl;
  logic [DATA_W-1:0] out_tr;
  logic [DATA_W-1:0] out_bl;
  logic [DATA_W-1:0] out_br;
  logic              frame_done;

  modport master (
    output enable, in_valid, in_data,
    input  out_valid, out_tl, out_tr, out_bl, out_br, frame_done
  );

  modport slave (
    input  enable, in_valid, in_data,
    output out_valid, out_tl, out_tr, out_bl, out_br, frame_done
  );
endinterface

// File: rtl/pool_window_gen.sv
// 2x2 stride-2 window generator feeding max_pooling from a raster pixel stream.
// Defining POOL_WIN_PAD_EN zero-pads the last column when IMG_W is odd.
module pool_window_gen #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int CNT_W  = 5
) (
  input  logic          clk,
  input  logic          rst,
  pool_window_if.slave  bus
);
  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);

  logic [CNT_W-1:0]  col_q, col_d;
  logic [CNT_W-1:0]  row_q, row_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] tl_q, tl_d;
  logic [DATA_W-1:0] tr_q, tr_d;
  logic [DATA_W-1:0] bl_q, bl_d;
  logic [DATA_W-1:0] br_q, br_d;
  logic              valid_q, valid_d;
  logic              fd_q, fd_d;

  logic [DATA_W-1:0] line_buf [IMG_W];
  logic              lb_we;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     rd_idx;
  logic              acc;
  logic              last_col;
  logic              last_row;

  assign acc      = bus.enable & bus.in_valid;
  assign last_col = (col_q == COL_LAST);
  assign last_row = (row_q == ROW_LAST);
  assign wr_idx   = col_q[AW-1:0];
  assign rd_idx   = wr_idx - AW'(1);

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    hold_d  = hold_q;
    tl_d    = tl_q;
    tr_d    = tr_q;
    bl_d    = bl_q;
    br_d    = br_q;
    valid_d = 1'b0;
    fd_d    = 1'b0;
    lb_we   = 1'b0;
    if (acc) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
      fd_d = last_col & last_row;
      if (!row_q[0]) begin
        lb_we = 1'b1;
      end else if (!col_q[0]) begin
        hold_d = bus.in_data;
`ifdef POOL_WIN_PAD_EN
        // An odd width leaves a lone last column. Zeros never win the unsigned max downstream.
        if ((IMG_W % 2 == 1) && last_col) begin
          tl_d    = line_buf[IMG_W-1];
          tr_d    = '0;
          bl_d    = bus.in_data;
          br_d    = '0;
          valid_d = 1'b1;
        end
`endif
      end else begin
        tl_d    = line_buf[rd_idx];
        tr_d    = line_buf[wr_idx];
        bl_d    = hold_q;
        br_d    = bus.in_data;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      hold_q  <= '0;
      tl_q    <= '0;
      tr_q    <= '0;
      bl_q    <= '0;
      br_q    <= '0;
      valid_q <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      hold_q  <= hold_d;
      tl_q    <= tl_d;
      tr_q    <= tr_d;
      bl_q    <= bl_d;
      br_q    <= br_d;
      valid_q <= valid_d;
      fd_q    <= fd_d;
    end
  end

  // The line buffer needs no reset: every even row rewrites it before an odd row reads it.
  always_ff @(posedge clk) begin
    if (!rst && lb_we) begin
      line_buf[wr_idx] <= bus.in_data;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_tl     = tl_q;
  assign bus.out_tr     = tr_q;
  assign bus.out_bl     = bl_q;
  assign bus.out_br     = br_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_pool_window_gen.sv
// Directed bench for pool_window_gen. It uses a 4x4 instance and a 5x4 instance.
// Window expectations for the 5x4 frame depend on POOL_WIN_PAD_EN.
module tb_pool_window_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pool_window_if #(.DATA_W(32)) b4 ();
  pool_window_if #(.DATA_W(32)) b5 ();

  pool_window_gen #(.DATA_W(32), .IMG_W(4), .IMG_H(4), .CNT_W(3)) u4 (
    .clk(clk), .rst(rst), .bus(b4)
  );
  pool_window_gen #(.DATA_W(32), .IMG_W(5), .IMG_H(4), .CNT_W(3)) u5 (
    .clk(clk), .rst(rst), .bus(b5)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // observation log filled by the driver
  logic [127:0] win_q[$];
  int           pulse_q[$];
  int           fd_q[$];
  int           acc_cnt;
  bit           stretch;
  bit           prev_v;
  bit           sel5;

  // expected windows and accept index of the pixel that triggers each window
  logic [127:0] exp_q[$];
  int           exp_at_q[$];

  task automatic clear_logs();
    win_q.delete(); pulse_q.delete(); fd_q.delete();
    exp_q.delete(); exp_at_q.delete();
    acc_cnt = 0; stretch = 0; prev_v = 0;
  endtask

  task automatic push_exp(input int a, input int b, input int c, input int d, input int at);
    exp_q.push_back({a[31:0], b[31:0], c[31:0], d[31:0]});
    exp_at_q.push_back(at);
  endtask

  task automatic cyc(input bit en, input bit vld, input logic [31:0] d);
    logic         v, fd;
    logic [127:0] w;
    if (sel5) begin
      b5.enable = en; b5.in_valid = vld; b5.in_data = d;
      b4.enable = 1'b1; b4.in_valid = 1'b0; b4.in_data = '0;
    end else begin
      b4.enable = en; b4.in_valid = vld; b4.in_data = d;
      b5.enable = 1'b1; b5.in_valid = 1'b0; b5.in_data = '0;
    end
    @(posedge clk);
    #1;
    if (en && vld && !rst) acc_cnt++;
    v  = sel5 ? b5.out_valid : b4.out_valid;
    fd = sel5 ? b5.frame_done : b4.frame_done;
    w  = sel5 ? {b5.out_tl, b5.out_tr, b5.out_bl, b5.out_br}
              : {b4.out_tl, b4.out_tr, b4.out_bl, b4.out_br};
    if (v) begin
      win_q.push_back(w);
      pulse_q.push_back((en && vld && !rst) ? acc_cnt : -1);
    end
    if (fd) fd_q.push_back((en && vld && !rst) ? acc_cnt : -1);
    if (v && prev_v) stretch = 1;
    prev_v = v;
  endtask

  task automatic feed(input int first, input int last);
    for (int p = first; p <= last; p++) cyc(1'b1, 1'b1, p[31:0]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 32'hbad0_0000 + i[31:0]);
  endtask

  task automatic test_reset();
    sel5 = 0;
    rst = 1'b1;
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    rst = 1'b0;
    cyc(1'b1, 1'b0, '0);
    n_tests++;
    if ({b4.out_tl, b4.out_tr, b4.out_bl, b4.out_br} !== 128'h0) begin
      n_fail++; $display("FAIL reset_win4 got %h want 0", {b4.out_tl, b4.out_tr, b4.out_bl, b4.out_br});
    end
    n_tests++;
    if (b4.out_valid !== 1'b0 || b4.frame_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulse4 got v=%b fd=%b want 0 0", b4.out_valid, b4.frame_done);
    end
    n_tests++;
    if ({b5.out_tl, b5.out_br} !== 64'h0 || b5.out_valid !== 1'b0 || b5.frame_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_5 got tl=%0d br=%0d v=%b fd=%b want 0", b5.out_tl, b5.out_br, b5.out_valid, b5.frame_done);
    end
  endtask

  task automatic test_basic();
    clear_logs(); sel5 = 0;
    feed(1, 16);
    idle(2);
    push_exp(1, 2, 5, 6, 6); push_exp(3, 4, 7, 8, 8);
    push_exp(9, 10, 13, 14, 14); push_exp(11, 12, 15, 16, 16);
    n_tests++;
    if (win_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL basic_count got %0d want %0d", win_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (i >= win_q.size() || win_q[i] !== exp_q[i] || pulse_q[i] !== exp_at_q[i]) begin
        n_fail++;
        $display("FAIL basic_win%0d got %h @%0d want %h @%0d", i,
                 (i < win_q.size()) ? win_q[i] : 128'h0, (i < pulse_q.size()) ? pulse_q[i] : -2,
                 exp_q[i], exp_at_q[i]);
      end
    end
    n_tests++;
    if (fd_q.size() !== 1 || fd_q[0] !== 16) begin
      n_fail++; $display("FAIL basic_frame_done got n=%0d at=%0d want 1 at 16", fd_q.size(), (fd_q.size() > 0) ? fd_q[0] : -2);
    end
    n_tests++;
    if ({b4.out_tl, b4.out_tr, b4.out_bl, b4.out_br} !== {32'd11, 32'd12, 32'd15, 32'd16} || b4.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_hold got %0d %0d %0d %0d v=%b want 11 12 15 16 v=0",
                         b4.out_tl, b4.out_tr, b4.out_bl, b4.out_br, b4.out_valid);
    end
  endtask

  task automatic test_gaps();
    clear_logs(); sel5 = 0;
    for (int p = 1; p <= 16; p++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) cyc(1'b1, 1'b0, $urandom);
      cyc(1'b1, 1'b1, p[31:0]);
    end
    idle(2);
    push_exp(1, 2, 5, 6, 6); push_exp(3, 4, 7, 8, 8);
    push_exp(9, 10, 13, 14, 14); push_exp(11, 12, 15, 16, 16);
    n_tests++;
    if (win_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL gaps_count got %0d want %0d", win_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (i >= win_q.size() || win_q[i] !== exp_q[i] || pulse_q[i] !== exp_at_q[i]) begin
        n_fail++;
        $display("FAIL gaps_win%0d got %h @%0d want %h @%0d", i,
                 (i < win_q.size()) ? win_q[i] : 128'h0, (i < pulse_q.size()) ? pulse_q[i] : -2,
                 exp_q[i], exp_at_q[i]);
      end
    end
    n_tests++;
    if (fd_q.size() !== 1 || fd_q[0] !== 16 || stretch) begin
      n_fail++; $display("FAIL gaps_frame_done got n=%0d stretch=%b want 1 0", fd_q.size(), stretch);
    end
  endtask

  task automatic test_enable();
    clear_logs(); sel5 = 0;
    feed(1, 7);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'd900 + i[31:0]);
    feed(8, 14);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 32'd950 + i[31:0]);
    feed(15, 16);
    idle(2);
    push_exp(1, 2, 5, 6, 6); push_exp(3, 4, 7, 8, 8);
    push_exp(9, 10, 13, 14, 14); push_exp(11, 12, 15, 16, 16);
    n_tests++;
    if (win_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL enable_count got %0d want %0d", win_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (i >= win_q.size() || win_q[i] !== exp_q[i] || pulse_q[i] !== exp_at_q[i]) begin
        n_fail++;
        $display("FAIL enable_win%0d got %h @%0d want %h @%0d", i,
                 (i < win_q.size()) ? win_q[i] : 128'h0, (i < pulse_q.size()) ? pulse_q[i] : -2,
                 exp_q[i], exp_at_q[i]);
      end
    end
    n_tests++;
    if (stretch) begin
      n_fail++; $display("FAIL enable_stretch got stretched pulse=1 want 0");
    end
    n_tests++;
    if (fd_q.size() !== 1 || fd_q[0] !== 16) begin
      n_fail++; $display("FAIL enable_frame_done got n=%0d want 1 at 16", fd_q.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_logs(); sel5 = 0;
    feed(1, 10);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 32'hdead_beef);
    rst = 1'b0;
    n_tests++;
    if ({b4.out_tl, b4.out_tr, b4.out_bl, b4.out_br} !== 128'h0 || b4.out_valid !== 1'b0 || b4.frame_done !== 1'b0) begin
      n_fail++; $display("FAIL midrst_zero got %0d %0d %0d %0d v=%b want 0",
                         b4.out_tl, b4.out_tr, b4.out_bl, b4.out_br, b4.out_valid);
    end
    clear_logs();
    feed(1, 16);
    idle(2);
    push_exp(1, 2, 5, 6, 6); push_exp(3, 4, 7, 8, 8);
    push_exp(9, 10, 13, 14, 14); push_exp(11, 12, 15, 16, 16);
    n_tests++;
    if (win_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL midrst_count got %0d want %0d", win_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (i >= win_q.size() || win_q[i] !== exp_q[i] || pulse_q[i] !== exp_at_q[i]) begin
        n_fail++;
        $display("FAIL midrst_win%0d got %h @%0d want %h @%0d", i,
                 (i < win_q.size()) ? win_q[i] : 128'h0, (i < pulse_q.size()) ? pulse_q[i] : -2,
                 exp_q[i], exp_at_q[i]);
      end
    end
  endtask

  task automatic test_odd_width();
    clear_logs(); sel5 = 1;
    feed(1, 20);
    idle(2);
    push_exp(1, 2, 6, 7, 7); push_exp(3, 4, 8, 9, 9);
`ifdef POOL_WIN_PAD_EN
    push_exp(5, 0, 10, 0, 10);
`endif
    push_exp(11, 12, 16, 17, 17); push_exp(13, 14, 18, 19, 19);
`ifdef POOL_WIN_PAD_EN
    push_exp(15, 0, 20, 0, 20);
`endif
    n_tests++;
    if (win_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL odd_count got %0d want %0d", win_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (i >= win_q.size() || win_q[i] !== exp_q[i] || pulse_q[i] !== exp_at_q[i]) begin
        n_fail++;
        $display("FAIL odd_win%0d got %h @%0d want %h @%0d", i,
                 (i < win_q.size()) ? win_q[i] : 128'h0, (i < pulse_q.size()) ? pulse_q[i] : -2,
                 exp_q[i], exp_at_q[i]);
      end
    end
    n_tests++;
    if (fd_q.size() !== 1 || fd_q[0] !== 20) begin
      n_fail++; $display("FAIL odd_frame_done got n=%0d at=%0d want 1 at 20", fd_q.size(), (fd_q.size() > 0) ? fd_q[0] : -2);
    end
    sel5 = 0;
  endtask

  task automatic test_back_to_back();
    clear_logs(); sel5 = 0;
    feed(1, 16);
    feed(101, 116);
    idle(2);
    push_exp(1, 2, 5, 6, 6); push_exp(3, 4, 7, 8, 8);
    push_exp(9, 10, 13, 14, 14); push_exp(11, 12, 15, 16, 16);
    push_exp(101, 102, 105, 106, 22); push_exp(103, 104, 107, 108, 24);
    push_exp(109, 110, 113, 114, 30); push_exp(111, 112, 115, 116, 32);
    n_tests++;
    if (win_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count got %0d want %0d", win_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (i >= win_q.size() || win_q[i] !== exp_q[i] || pulse_q[i] !== exp_at_q[i]) begin
        n_fail++;
        $display("FAIL b2b_win%0d got %h @%0d want %h @%0d", i,
                 (i < win_q.size()) ? win_q[i] : 128'h0, (i < pulse_q.size()) ? pulse_q[i] : -2,
                 exp_q[i], exp_at_q[i]);
      end
    end
    n_tests++;
    if (fd_q.size() !== 2 || fd_q[0] !== 16 || fd_q[1] !== 32) begin
      n_fail++; $display("FAIL b2b_frame_done got n=%0d want 2 at 16,32", fd_q.size());
    end
  endtask

  initial begin
    b4.enable = 1'b0; b4.in_valid = 1'b0; b4.in_data = '0;
    b5.enable = 1'b0; b5.in_valid = 1'b0; b5.in_data = '0;
    sel5 = 0;
    test_reset();
    test_basic();
    test_gaps();
    test_enable();
    test_reset_mid();
    test_odd_width();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pool_window_gen.md
Name: pool_window_gen

Overview:
Streaming producer that feeds max_pooling. It accepts a raster-scan feature map, one pixel per accepted beat. For every non-overlapping 2x2 window (stride 2) it emits the four window values in parallel, in the port order max_pooling expects. A one-line buffer holds the even (upper) row while the odd (lower) row arrives.

Parameters:
DATA_W, 32, pixel width in bits
IMG_W, 28, pixels per row (>=2)
IMG_H, 28, rows per frame (>=2)
CNT_W, 5, counter width; must satisfy 2^CNT_W >= max(IMG_W, IMG_H)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset; synchronous, active-high
enable  in  1  global stall; low freezes all state and outputs
in_valid  in  1  in_data valid this cycle; sampled only when enable=1
in_data  in  DATA_W  pixel, raster order, row-major
out_valid  out  1  one-cycle pulse: window outputs valid
out_tl  out  DATA_W  top-left pixel -> max_pooling input1
out_tr  out  DATA_W  top-right pixel -> input2
out_bl  out  DATA_W  bottom-left pixel -> input3
out_br  out  DATA_W  bottom-right pixel -> input4
frame_done  out  1  one-cycle pulse on the last accepted pixel of a frame

Behaviour:
- Accept condition: acc = enable & in_valid. No backpressure; the upstream block owns pacing.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance only on acc.
  - col wraps to 0 after IMG_W-1 and row increments.
  - At row=IMG_H-1 with col=IMG_W-1 both counters wrap to 0 (next frame).
- Even row (row[0]=0): on acc, line_buf[col] <= in_data. No output.
- Odd row, even col: on acc, hold_reg <= in_data (bottom-left candidate).
- Odd row, odd col: on acc, register outputs next edge:
  - out_tl=line_buf[col-1], out_tr=line_buf[col]
  - out_bl=hold_reg, out_br=in_data
  - out_valid=1 for exactly one cycle
- Latency: window outputs and out_valid are valid 1 cycle after the accept of the bottom-right pixel.
- Window outputs hold their last value between pulses. out_valid=0 on every cycle without a qualifying accept.
- frame_done: registered. Pulses 1 cycle after the accept at row=IMG_H-1, col=IMG_W-1, coincident with the final out_valid when IMG_W and IMG_H are both even.
- Odd IMG_W: last column is dropped (floor), but its pixel is still accepted and counted; see optional feature.
- Odd IMG_H: last row is accepted, written to line_buf, and produces no output. frame_done still fires on its last pixel.
- enable=0:
  - counters, line_buf, hold_reg and outputs freeze.
  - out_valid and frame_done are forced 0 for that cycle, so a pulse is never stretched.
  - in_valid is ignored.
- rst=1 (any time, including mid-frame):
  - col=0, row=0, hold_reg=0
  - out_tl/tr/bl/br=0, out_valid=0, frame_done=0
  - line_buf contents are don't-care; they are rewritten before being read.
  - rst overrides enable.
- Windows per frame: floor(IMG_W/2)*floor(IMG_H/2).

Optional Feature:
Macro POOL_WIN_PAD_EN.
- Defined, with IMG_W odd: on acc at odd row and col=IMG_W-1, emit a padded window next cycle with out_valid=1:
  - out_tl=line_buf[IMG_W-1], out_tr=0
  - out_bl=in_data, out_br=0
  - Zero is neutral for the unsigned max compare downstream.
  - Windows per frame: ceil(IMG_W/2)*floor(IMG_H/2).
- Not defined, or IMG_W even: last-column pixel produces no output (floor behaviour above). No padding logic is synthesized.

Test Plan:
1. IMG_W=4, IMG_H=4; feed 1..16 with in_valid held high. Required: 4 out_valid pulses with (tl,tr,bl,br) = (1,2,5,6), (3,4,7,8), (9,10,13,14), (11,12,15,16). Each pulse 1 cycle after pixels 6, 8, 14, 16. frame_done coincident with the 4th pulse.
2. Same frame with in_valid deasserted on random cycles (gaps of 1-3). Required: identical window values and order; each pulse exactly 1 cycle after its bottom-right accept.
3. Drop enable for 3 cycles right after pixel 7, with in_valid high throughout. Required: no state advance and no pulses while enable=0. The pixel present on the first enable=1 cycle is taken as pixel 8. Window (3,4,7,8) is emitted afterward; out_valid is never longer than 1 cycle.
4. Assert rst for 1 cycle after pixel 10, then feed a fresh 1..16 frame. Required: outputs 0 and out_valid=0 after reset. Then the exact four windows of test 1, with no stale values.
5. IMG_W=5, IMG_H=4; feed 1..20.
   - Without POOL_WIN_PAD_EN: windows (1,2,6,7), (3,4,8,9), (11,12,16,17), (13,14,18,19).
   - With the macro: additionally (5,0,10,0) after pixel 10 and (15,0,20,0) after pixel 20.
   - frame_done after pixel 20 in both builds.
6. Two back-to-back 4x4 frames (1..16, then 101..116) with no gap. Required: 8 windows; the second frame's first window is (101,102,105,106). frame_done pulses twice.
